// File: rtl/bram_test_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_test_master_pkg
//  Description : Shared types, pattern codes and the data-pattern function
//                for the BRAM test master and its bench.
//  Revision    : 1.0  initial release
// ============================================================================
package bram_test_master_pkg;

    // Test-sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Data pattern selector codes
    localparam logic [1:0] PAT_ADDR    = 2'd0;
    localparam logic [1:0] PAT_INV     = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_ONES    = 2'd3;

    // Widest word the pattern function can produce; callers truncate
    localparam int c_PAT_MAX_W = 256;

    // Word written to / expected from address addr for a given pattern code.
    // The address is zero-extended before inversion, so truncating the wide
    // result to the data width matches inverting at the data width.
    function automatic logic [c_PAT_MAX_W-1:0] pattern_word(
        input logic [1:0]  code,
        input logic [31:0] addr
    );
        logic [c_PAT_MAX_W-1:0] w_ext;
        w_ext = {{(c_PAT_MAX_W-32){1'b0}}, addr};
        case (code)
            PAT_ADDR:    pattern_word = w_ext;
            PAT_INV:     pattern_word = ~w_ext;
            PAT_CHECKER: pattern_word = addr[0] ? {(c_PAT_MAX_W/2){2'b10}}
                                                : {(c_PAT_MAX_W/2){2'b01}};
            default:     pattern_word = '1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_test_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_test_master_if
//  Description : Control/status and BRAM port bundle of the test master.
//                master = test initiator, slave = memory + controller side.
//  Revision    : 1.0  initial release
// ============================================================================
interface bram_test_master_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 11,
    parameter int COUNT_BITS   = 16
);
    logic                    start;
    logic [1:0]              pattern;
    logic                    read;
    logic                    write;
    logic [ADDRESS_BITS-1:0] read_address;
    logic [ADDRESS_BITS-1:0] write_address;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [COUNT_BITS-1:0]   error_count;
    logic [ADDRESS_BITS-1:0] first_error_address;

    modport master (
        input  start, pattern, in_data,
        output read, write, read_address, write_address, out_data,
               busy, done, pass, error_count, first_error_address
    );

    modport slave (
        output start, pattern, in_data,
        input  read, write, read_address, write_address, out_data,
               busy, done, pass, error_count, first_error_address
    );
endinterface
`default_nettype wire

// File: rtl/bram_test_expect_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_test_expect_pipe
//  Description : Valid/address delay line matching the memory read latency,
//                so each returned word can be paired with its address.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_test_expect_pipe #(
    parameter int DEPTH        = 3,
    parameter int ADDRESS_BITS = 11
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_valid,
    input  wire logic [ADDRESS_BITS-1:0] i_address,
    output logic                         o_valid,
    output logic [ADDRESS_BITS-1:0]      o_address
);
    logic [DEPTH-1:0]        r_valid;
    logic [ADDRESS_BITS-1:0] r_address [DEPTH];

    // Shift valid/address one stage per cycle; reset empties the line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_address[i] <= '0;
            end
        end else begin
            r_valid[0]   <= i_valid;
            r_address[0] <= i_address;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i]   <= r_valid[i-1];
                r_address[i] <= r_address[i-1];
            end
        end
    end

    assign o_valid   = r_valid[DEPTH-1];
    assign o_address = r_address[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bram_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : bram_test_master
//  Description : Self-checking memory tester. Fills every word with a pattern,
//                pauses, reads everything back and counts mismatches.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_test_master
    import bram_test_master_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 11,
    parameter int READ_LATENCY = 3,
    parameter int WR_GAP       = 2,
    parameter int COUNT_BITS   = 16
) (
    input  wire logic          clock,
    input  wire logic          reset,
    bram_test_master_if.master bus
);
    // One counter serves both the GAP and FLUSH dwell times
    localparam int c_CNT_MAX = (WR_GAP > READ_LATENCY) ? WR_GAP : READ_LATENCY;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(WR_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_FLUSH_LAST = c_CNT_W'(READ_LATENCY - 1);

    state_t                  r_state;
    logic [1:0]              r_pat;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_read;
    logic                    r_write;
    logic [ADDRESS_BITS-1:0] r_raddr;
    logic [ADDRESS_BITS-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [COUNT_BITS-1:0]   r_err_cnt;
    logic [ADDRESS_BITS-1:0] r_first_err;

    logic                    w_pipe_valid;
    logic [ADDRESS_BITS-1:0] w_pipe_addr;
    logic [DATA_WIDTH-1:0]   w_expect;
    logic                    w_mismatch;
    logic [COUNT_BITS-1:0]   w_err_next;
    logic [ADDRESS_BITS-1:0] w_first_next;
    logic [ADDRESS_BITS-1:0] w_waddr_next;

    // Pairs each read request with the cycle its data returns
    bram_test_expect_pipe #(
        .DEPTH        (READ_LATENCY),
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_expect_pipe (
        .clk       (clock),
        .rst       (reset),
        .i_valid   (r_read),
        .i_address (r_raddr),
        .o_valid   (w_pipe_valid),
        .o_address (w_pipe_addr)
    );

    // Compare returning data and form the next error statistics
    always_comb begin
        w_expect     = DATA_WIDTH'(pattern_word(r_pat, 32'(w_pipe_addr)));
        w_mismatch   = w_pipe_valid && (bus.in_data != w_expect);
        w_err_next   = r_err_cnt;
        w_first_next = r_first_err;
        w_waddr_next = r_waddr + 1'b1;
        if (w_mismatch) begin
            if (r_err_cnt != '1) begin
                w_err_next = r_err_cnt + 1'b1;
            end
            // Capture the address only on the first mismatch of the test
            if (r_err_cnt == '0) begin
                w_first_next = w_pipe_addr;
            end
        end
    end

    // Test sequencer with registered bus and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pat       <= PAT_ADDR;
            r_cnt       <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else begin
            r_err_cnt   <= w_err_next;
            r_first_err <= w_first_next;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_pat       <= bus.pattern;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_write     <= 1'b1;
                        r_waddr     <= '0;
                        r_wdata     <= DATA_WIDTH'(pattern_word(bus.pattern, 32'd0));
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Counter wraps to zero after the last word
                    r_waddr <= w_waddr_next;
                    r_wdata <= DATA_WIDTH'(pattern_word(r_pat, 32'(w_waddr_next)));
                    if (r_waddr == '1) begin
                        r_write <= 1'b0;
                        r_cnt   <= '0;
                        if (WR_GAP == 0) begin
                            r_read  <= 1'b1;
                            r_raddr <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_read  <= 1'b1;
                        r_raddr <= '0;
                        r_state <= S_READ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    r_raddr <= r_raddr + 1'b1;
                    if (r_raddr == '1) begin
                        r_read  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Last compare lands on this edge, so pass uses the next count
                    if (r_cnt == c_FLUSH_LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.read                = r_read;
    assign bus.write               = r_write;
    assign bus.read_address        = r_raddr;
    assign bus.write_address       = r_waddr;
    assign bus.out_data            = r_wdata;
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.pass                = r_pass;
    assign bus.error_count         = r_err_cnt;
    assign bus.first_error_address = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_bram_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_test_master
//  Description : Self-checking bench: two testers (16-bit and 2-bit error
//                counters) on behavioural 16-word memories with fault masks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_test_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  pat   = 2'd0;

    int checks = 0;
    int errors = 0;

    // Fault masks for memory A: read = (stored & andm) ^ xorm
    logic [31:0] andm [16];
    logic [31:0] xorm [16];

    // Memory models, 3-cycle registered read
    logic [31:0] mema [16];
    logic [31:0] memb [16];
    logic [31:0] da [3];
    logic [31:0] db [3];
    logic [3:0]  aa [3];

    // Run observations
    int          done_cyc, ndone, wcnt, rcnt, overlap;
    logic        busy1, busy_at, pass_at, pass_b_at;
    logic [15:0] err_at;
    logic [3:0]  fea_at, fea_b_at;
    logic [1:0]  err_b_at;

    // Scoreboard results
    int          exp_n;
    int          exp_first;

    bram_test_master_if #(.DATA_WIDTH(32), .ADDRESS_BITS(4), .COUNT_BITS(16)) ifa ();
    bram_test_master_if #(.DATA_WIDTH(32), .ADDRESS_BITS(4), .COUNT_BITS(2))  ifb ();

    bram_test_master #(
        .DATA_WIDTH(32), .ADDRESS_BITS(4), .READ_LATENCY(3), .WR_GAP(2), .COUNT_BITS(16)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.master)
    );

    bram_test_master #(
        .DATA_WIDTH(32), .ADDRESS_BITS(4), .READ_LATENCY(3), .WR_GAP(2), .COUNT_BITS(2)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.master)
    );

    always #5 clock = ~clock;

    assign ifa.start   = start;
    assign ifa.pattern = pat;
    assign ifb.start   = start;
    assign ifb.pattern = pat;

    always @(posedge clock) begin
        if (ifa.write) mema[ifa.write_address] <= ifa.out_data;
        if (ifb.write) memb[ifb.write_address] <= ifb.out_data;
        da[0] <= mema[ifa.read_address];
        aa[0] <= ifa.read_address;
        db[0] <= memb[ifb.read_address];
        for (int i = 1; i < 3; i++) begin
            da[i] <= da[i-1];
            aa[i] <= aa[i-1];
            db[i] <= db[i-1];
        end
    end

    assign ifa.in_data = (da[2] & andm[aa[2]]) ^ xorm[aa[2]];
    assign ifb.in_data = ~db[2];

    function automatic logic [31:0] model_word(input logic [1:0] p, input int a);
        case (p)
            2'd0:    return 32'(a);
            2'd1:    return 32'hFFFF_FFFF - 32'(a);
            2'd2:    return (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_masks();
        for (int i = 0; i < 16; i++) begin
            andm[i] = 32'hFFFF_FFFF;
            xorm[i] = 32'h0;
        end
    endtask

    task automatic score(input logic [1:0] p);
        logic [31:0] w;
        exp_n     = 0;
        exp_first = 0;
        for (int a = 0; a < 16; a++) begin
            w = model_word(p, a);
            if (((w & andm[a]) ^ xorm[a]) != w) begin
                if (exp_n == 0) exp_first = a;
                exp_n++;
            end
        end
    endtask

    // Start a test with pattern p; optionally re-pulse start at cycle poke
    task automatic run_test(input logic [1:0] p, input int poke);
        done_cyc = 0; ndone = 0; wcnt = 0; rcnt = 0; overlap = 0; busy1 = 1'b0;
        @(negedge clock);
        pat   = p;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        pat = 2'($urandom);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clock);
            start = (cyc == poke);
            if (cyc == 1) busy1 = ifa.busy;
            if (ifa.write) wcnt++;
            if (ifa.read) rcnt++;
            if (ifa.read && ifa.write) overlap++;
            if (ifa.done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc  = cyc;
                    busy_at   = ifa.busy;
                    pass_at   = ifa.pass;
                    err_at    = ifa.error_count;
                    fea_at    = ifa.first_error_address;
                    err_b_at  = ifb.error_count;
                    fea_b_at  = ifb.first_error_address;
                    pass_b_at = ifb.pass;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [1:0] p);
        score(p);
        check({tag, " done_cycle"}, 64'(done_cyc), 64'd38);
        check({tag, " done_count"}, 64'(ndone), 64'd1);
        check({tag, " write_cycles"}, 64'(wcnt), 64'd16);
        check({tag, " read_cycles"}, 64'(rcnt), 64'd16);
        check({tag, " rw_overlap"}, 64'(overlap), 64'd0);
        check({tag, " busy_start"}, 64'(busy1), 64'd1);
        check({tag, " busy_done"}, 64'(busy_at), 64'd0);
        check({tag, " error_count"}, 64'(err_at), 64'(exp_n));
        check({tag, " first_err"}, 64'(fea_at), 64'(exp_first));
        check({tag, " pass"}, 64'(pass_at), 64'(exp_n == 0));
        check({tag, " pass_held"}, 64'(ifa.pass), 64'(exp_n == 0));
        check({tag, " sat_count"}, 64'(err_b_at), 64'd3);
        check({tag, " sat_first"}, 64'(fea_b_at), 64'd0);
        check({tag, " sat_pass"}, 64'(pass_b_at), 64'd0);
    endtask

    initial begin
        clear_masks();
        repeat (3) @(negedge clock);
        check("rst read", 64'(ifa.read), 64'd0);
        check("rst write", 64'(ifa.write), 64'd0);
        check("rst busy", 64'(ifa.busy), 64'd0);
        check("rst done", 64'(ifa.done), 64'd0);
        check("rst pass", 64'(ifa.pass), 64'd0);
        check("rst errcnt", 64'(ifa.error_count), 64'd0);
        check("rst first", 64'(ifa.first_error_address), 64'd0);
        check("rst wdata", 64'(ifa.out_data), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Healthy memory, address pattern
        run_test(2'd0, 0);
        check_run("pat0", 2'd0);

        // Bit 0 flipped on readback of addresses 5 and 9
        xorm[5] = 32'h1;
        xorm[9] = 32'h1;
        run_test(2'd1, 0);
        check_run("pat1_flip", 2'd1);
        clear_masks();

        // Data bit 31 stuck at 0
        for (int i = 0; i < 16; i++) andm[i] = 32'h7FFF_FFFF;
        run_test(2'd2, 0);
        check_run("pat2_stuck", 2'd2);
        clear_masks();

        // start pulsed while busy must be ignored
        run_test(2'd0, 10);
        check_run("busy_start", 2'd0);

        // Reset during READ aborts the test
        @(negedge clock);
        pat   = 2'd0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (20) @(negedge clock);
        check("abort reading", 64'(ifa.read), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort read", 64'(ifa.read), 64'd0);
        check("abort write", 64'(ifa.write), 64'd0);
        check("abort busy", 64'(ifa.busy), 64'd0);
        check("abort done", 64'(ifa.done), 64'd0);
        check("abort b_busy", 64'(ifb.busy), 64'd0);
        check("abort b_read", 64'(ifb.read), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run_test(2'd3, 0);
        check_run("pat3_after_abort", 2'd3);

        // Randomised patterns and sparse readback faults
        for (int t = 0; t < 4; t++) begin
            logic [1:0] rp;
            int         nf;
            clear_masks();
            rp = 2'($urandom_range(0, 3));
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                int a;
                a = $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 1)
                    xorm[a] = 32'h1 << $urandom_range(0, 31);
                else
                    andm[a] = ~(32'h1 << $urandom_range(0, 31));
            end
            run_test(rp, 0);
            check_run($sformatf("rand%0d", t), rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
